// File: rtl/rpi_serial_port_pkg.sv
// Shared definitions for the RPi-side serial engine: register select codes
// and FSM state encodings.
package rpi_serial_port_pkg;

  // Register select codes driven by the RPi on regsel.
  localparam logic [1:0] REGSEL_RD = 2'b00;
  localparam logic [1:0] REGSEL_RC = 2'b01;
  localparam logic [1:0] REGSEL_TD = 2'b10;
  localparam logic [1:0] REGSEL_TC = 2'b11;

  // Frame engine states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_SHIFT = 2'd1,
    ST_RD_SHIFT = 2'd2,
    ST_COMMIT   = 2'd3
  } state_e;

endpackage

// File: rtl/rpi_serial_port_sync_edge.sv
// Multi-flop synchronizer for one asynchronous level, followed by a single
// extra flop that turns the synchronized level into a one-clock rising pulse.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  // Shift the raw input through the synchronizer chain and track the last synced level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer flops carry no reset so a level held across reset never fakes an edge.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
    prev_q <= prev_d;
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rpi_serial_port.sv
// RPi-side serial engine for the TIPI register file. Oversamples the RPi's
// bit-banged bus with the board clock, assembles RD/RC bytes written by the
// RPi and shifts TD/TC snapshots back out, MSB first.
module rpi_serial_port
  import rpi_serial_port_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rpi_sclk,
  input  logic             rpi_sle,
  input  logic [1:0]       rpi_regsel,
  input  logic             rpi_sdata_in,
  output logic             rpi_sdata_out,
  input  logic [WIDTH-1:0] td_in,
  input  logic [WIDTH-1:0] tc_in,
  output logic [WIDTH-1:0] rd_out,
  output logic [WIDTH-1:0] rc_out,
  output logic             rd_wr,
  output logic             rc_wr,
  output logic             frame_err,
  input  logic             err_clr
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sclk_rise;
  logic sle_rise;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_edge (
    .clk      (clk),
    .async_in (rpi_sclk),
    .rise     (sclk_rise)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sle_edge (
    .clk      (clk),
    .async_in (rpi_sle),
    .rise     (sle_rise)
  );

  // regsel and sdata go through a chain of the same depth as the edge
  // detectors, so a sampled bit lines up with the edge that qualifies it.
  logic [SYNC_STAGES-1:0][2:0] dsync_q;
  logic [SYNC_STAGES-1:0][2:0] dsync_d;
  logic [1:0]                  regsel_s;
  logic                        sdata_s;

  // Advance the regsel/sdata synchronizer chain.
  always_comb begin
    dsync_d[0] = {rpi_regsel, rpi_sdata_in};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      dsync_d[i] = dsync_q[i-1];
    end
  end

  // Data synchronizer flops, unreset for the same reason as the edge chains.
  always_ff @(posedge clk) begin
    dsync_q <= dsync_d;
  end

  assign regsel_s = dsync_q[SYNC_STAGES-1][2:1];
  assign sdata_s  = dsync_q[SYNC_STAGES-1][0];

  // Both edges in one clock: sle is honoured, the sclk edge is lost and flagged.
  logic both_rise;
  assign both_rise = sle_rise & sclk_rise;

  state_e state_q;
  state_e state_d;

  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] sh_q,        sh_d;
  logic [1:0]       sel_q,       sel_d;
  logic [WIDTH-1:0] rd_out_q,    rd_out_d;
  logic [WIDTH-1:0] rc_out_q,    rc_out_d;
  logic             rd_wr_q,     rd_wr_d;
  logic             rc_wr_q,     rc_wr_d;
  logic             sdo_q,       sdo_d;
  logic             frame_err_q, frame_err_d;
  logic             err_set;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode from synchronized edges and the locked register select.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sle_rise) begin
          if (regsel_s[1]) state_d = ST_RD_SHIFT;
        end else if (sclk_rise && !regsel_s[1]) begin
          state_d = ST_WR_SHIFT;
        end
      end
      ST_WR_SHIFT: begin
        if (regsel_s != sel_q) begin
          state_d = ST_IDLE;
        end else if (sle_rise) begin
          state_d = (cnt_q == CNT_FULL) ? ST_COMMIT : ST_IDLE;
        end
      end
      ST_RD_SHIFT: begin
        if (!sle_rise && sclk_rise && cnt_q == CNT_LAST) state_d = ST_IDLE;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and output decode: shifting, snapshots, commits and error flagging.
  always_comb begin
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    sel_d    = sel_q;
    rd_out_d = rd_out_q;
    rc_out_d = rc_out_q;
    rd_wr_d  = 1'b0;
    rc_wr_d  = 1'b0;
    sdo_d    = sdo_q;
    err_set  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sle_rise) begin
          err_set = both_rise;
          if (regsel_s[1]) begin
            sh_d  = regsel_s[0] ? tc_in : td_in;
            sdo_d = regsel_s[0] ? tc_in[WIDTH-1] : td_in[WIDTH-1];
            cnt_d = '0;
            sel_d = regsel_s;
          end else begin
            err_set = 1'b1;
          end
        end else if (sclk_rise && !regsel_s[1]) begin
          sh_d  = {sh_q[WIDTH-2:0], sdata_s};
          cnt_d = CNT_ONE;
          sel_d = regsel_s;
        end
      end
      ST_WR_SHIFT: begin
        if (regsel_s != sel_q) begin
          err_set = 1'b1;
          cnt_d   = '0;
        end else if (sle_rise) begin
          err_set = both_rise;
          if (cnt_q != CNT_FULL) begin
            err_set = 1'b1;
            cnt_d   = '0;
          end
        end else if (sclk_rise) begin
          if (cnt_q < CNT_FULL) begin
            sh_d  = {sh_q[WIDTH-2:0], sdata_s};
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        if (sel_q == REGSEL_RD) begin
          rd_out_d = sh_q;
          rd_wr_d  = 1'b1;
        end else begin
          rc_out_d = sh_q;
          rc_wr_d  = 1'b1;
        end
        cnt_d = '0;
      end
      ST_RD_SHIFT: begin
        if (sle_rise) begin
          // Restart: fresh snapshot of the same latch, TI writes since are picked up.
          err_set = both_rise;
          sh_d    = sel_q[0] ? tc_in : td_in;
          sdo_d   = sel_q[0] ? tc_in[WIDTH-1] : td_in[WIDTH-1];
          cnt_d   = '0;
        end else if (sclk_rise) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            sdo_d = 1'b0;
          end else begin
            // Shift the snapshot up so the next bit is always presented from the top.
            cnt_d = cnt_q + CNT_ONE;
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            sdo_d = sh_q[WIDTH-2];
          end
        end
      end
      default: cnt_d = '0;
    endcase
    frame_err_d = err_clr ? 1'b0 : (frame_err_q | err_set);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sh_q        <= '0;
      sel_q       <= REGSEL_RD;
      rd_out_q    <= '0;
      rc_out_q    <= '0;
      rd_wr_q     <= 1'b0;
      rc_wr_q     <= 1'b0;
      sdo_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      sel_q       <= sel_d;
      rd_out_q    <= rd_out_d;
      rc_out_q    <= rc_out_d;
      rd_wr_q     <= rd_wr_d;
      rc_wr_q     <= rc_wr_d;
      sdo_q       <= sdo_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rpi_sdata_out = sdo_q;
  assign rd_out        = rd_out_q;
  assign rc_out        = rc_out_q;
  assign rd_wr         = rd_wr_q;
  assign rc_wr         = rc_wr_q;
  assign frame_err     = frame_err_q;

endmodule
